// File: rtl/t05_huffman_decoder.sv
// Huffman decoder: walks the code tree in node SRAM one fetch per code bit, emitting a character per leaf.
// Latency 2L+1 cycles per symbol of code length L; node_req/bit_ready/char_valid each hold until their handshake.
module t05_huffman_decoder #(
  parameter logic [3:0] EN_CODE   = 4'd6,
  parameter logic [8:0] MAX_DEPTH = 9'd256
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [3:0]  en_state,
  input  logic [7:0]  root_idx,
  input  logic [31:0] total_chars,
  output logic        node_req,
  output logic [7:0]  node_addr,
  input  logic        node_ack,
  input  logic [17:0] node_data,
  input  logic        bit_valid,
  input  logic        bit_in,
  output logic        bit_ready,
  output logic        char_valid,
  output logic [7:0]  char_out,
  input  logic        char_ready,
  output logic        err,
  output logic [3:0]  fin_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_WAIT_BIT = 3'd2,
    S_EMIT     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_cur;
  logic [17:0] r_node;
  logic [8:0]  r_depth;
  logic [31:0] r_count;
  logic [7:0]  r_char;
  logic        r_err;

  logic        w_en;
  logic        w_abort;
  logic [8:0]  w_child;
  logic [8:0]  w_depth_inc;
  logic [31:0] w_count_inc;
  logic        w_depth_hit;
  logic        w_last_char;

  assign w_en        = (en_state == EN_CODE);
  assign w_abort     = (r_state != S_IDLE) && !w_en;
  assign w_child     = bit_in ? r_node[8:0] : r_node[17:9];
  assign w_depth_inc = r_depth + 9'd1;
  assign w_count_inc = r_count + 32'd1;
  assign w_depth_hit = (w_depth_inc >= MAX_DEPTH);
  assign w_last_char = (w_count_inc == total_chars);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_en) begin
            w_next = (total_chars == 32'd0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          if (node_ack) begin
            w_next = S_WAIT_BIT;
          end
        end
        S_WAIT_BIT: begin
          if (bit_valid) begin
            // A leaf always wins, even on the edge that reaches the depth limit.
            if (!w_child[8]) begin
              w_next = S_EMIT;
            end else if (w_depth_hit) begin
              w_next = S_DONE;
            end else begin
              w_next = S_FETCH;
            end
          end
        end
        S_EMIT: begin
          if (char_ready) begin
            w_next = w_last_char ? S_DONE : S_FETCH;
          end
        end
        S_DONE:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cur   <= 8'd0;
      r_node  <= 18'd0;
      r_depth <= 9'd0;
      r_count <= 32'd0;
      r_char  <= 8'd0;
      r_err   <= 1'b0;
    end else if (w_abort) begin
      r_cur   <= 8'd0;
      r_node  <= 18'd0;
      r_depth <= 9'd0;
      r_count <= 32'd0;
      r_char  <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_en && (total_chars != 32'd0)) begin
            r_cur   <= root_idx;
            r_depth <= 9'd0;
            r_count <= 32'd0;
          end
        end
        S_FETCH: begin
          if (node_ack) begin
            r_node <= node_data;
          end
        end
        S_WAIT_BIT: begin
          if (bit_valid) begin
            r_depth <= w_depth_inc;
            if (w_child[8]) begin
              r_cur <= w_child[7:0];
              if (w_depth_hit) begin
                r_err <= 1'b1;
              end
            end else begin
              r_char <= w_child[7:0];
            end
          end
        end
        S_EMIT: begin
          if (char_ready) begin
            r_count <= w_count_inc;
            if (!w_last_char) begin
              r_cur   <= root_idx;
              r_depth <= 9'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs are gated by enable so an abort cycle never completes a transfer.
  always_comb begin
    node_req   = 1'b0;
    bit_ready  = 1'b0;
    char_valid = 1'b0;
    fin_state  = 4'd0;
    case (r_state)
      S_FETCH:    node_req   = w_en;
      S_WAIT_BIT: bit_ready  = w_en;
      S_EMIT:     char_valid = w_en;
      S_DONE:     fin_state  = EN_CODE;
      default: ;
    endcase
  end

  assign node_addr = r_cur;
  assign char_out  = r_char;
  assign err       = r_err;

endmodule

// File: tb/tb_t05_huffman_decoder.sv
// Directed bench for t05_huffman_decoder: behavioural node SRAM, bit source and char sink around one DUT.
module tb_t05_huffman_decoder;
  logic        clk = 1'b0;
  logic        nrst;
  logic [3:0]  en_state;
  logic [7:0]  root_idx;
  logic [31:0] total_chars;
  logic        node_req;
  logic [7:0]  node_addr;
  logic        node_ack;
  logic [17:0] node_data;
  logic        bit_valid;
  logic        bit_in;
  logic        bit_ready;
  logic        char_valid;
  logic [7:0]  char_out;
  logic        char_ready;
  logic        err;
  logic [3:0]  fin_state;

  t05_huffman_decoder #(.EN_CODE(4'd6), .MAX_DEPTH(9'd4)) dut (
    .clk(clk), .nrst(nrst), .en_state(en_state), .root_idx(root_idx),
    .total_chars(total_chars), .node_req(node_req), .node_addr(node_addr),
    .node_ack(node_ack), .node_data(node_data), .bit_valid(bit_valid),
    .bit_in(bit_in), .bit_ready(bit_ready), .char_valid(char_valid),
    .char_out(char_out), .char_ready(char_ready), .err(err), .fin_state(fin_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Node SRAM: 0/1 = three-symbol tree, 2 = right-recursive chain, 3 = single-symbol root.
  logic [17:0] mem [0:7];
  logic [3:0]  ack_dly;
  logic [3:0]  wcnt;
  logic        clr;
  assign node_data = mem[node_addr[2:0]];
  assign node_ack  = node_req && (wcnt == ack_dly);

  logic [15:0] bits_cur;
  logic [4:0]  nbits_cur;
  logic [4:0]  bit_idx;
  assign bit_valid = (bit_idx < nbits_cur);
  assign bit_in    = bits_cur[bit_idx[3:0]];

  logic [7:0]  cap [0:7];
  logic [3:0]  cap_n;
  logic [3:0]  run;
  logic [7:0]  last_addr;
  int          run_bad;
  int          req_cnt;
  int          br_cnt;

  always @(posedge clk) begin
    if (clr) begin
      wcnt <= 4'd0; bit_idx <= 5'd0; cap_n <= 4'd0;
      run <= 4'd0; run_bad <= 0; req_cnt <= 0; br_cnt <= 0;
    end else begin
      wcnt <= (!node_req || node_ack) ? 4'd0 : wcnt + 4'd1;
      if (bit_valid && bit_ready) bit_idx <= bit_idx + 5'd1;
      if (bit_ready) br_cnt <= br_cnt + 1;
      if (char_valid && char_ready && cap_n < 4'd8) begin
        cap[cap_n[2:0]] <= char_out;
        cap_n <= cap_n + 4'd1;
      end
      if (node_req) begin
        req_cnt <= req_cnt + 1;
        last_addr <= node_addr;
        if ((run != 4'd0 && node_addr != last_addr) || (node_ack && run != ack_dly))
          run_bad <= run_bad + 1;
        run <= node_ack ? 4'd0 : run + 4'd1;
      end else begin
        run <= 4'd0;
      end
    end
  end

  typedef struct {
    logic [7:0]  root;
    logic [15:0] bits;
    logic [4:0]  nbits;
    logic [31:0] tot;
    logic [3:0]  dly;
    int          exp_n;
    logic [31:0] exp_c;
    int          exp_used;
    logic        exp_err;
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [7:0] r, input logic [15:0] b, input logic [4:0] nb,
                      input logic [31:0] t, input logic [3:0] d);
    @(negedge clk);
    root_idx = r; bits_cur = b; nbits_cur = nb; total_chars = t; ack_dly = d;
    char_ready = 1'b1; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic wait_fin(input string nm);
    int n = 0;
    while (fin_state != 4'd6 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_fin"}, {28'd0, fin_state}, 32'd6);
  endtask

  task automatic chk_abc(input string nm);
    chk({nm, "_n"}, {28'd0, cap_n}, 32'd3);
    chk({nm, "_c0"}, {24'd0, cap[0]}, 32'h41);
    chk({nm, "_c1"}, {24'd0, cap[1]}, 32'h42);
    chk({nm, "_c2"}, {24'd0, cap[2]}, 32'h43);
  endtask

  initial begin
    mem[0] = {9'h041, 9'h101};
    mem[1] = {9'h042, 9'h043};
    mem[2] = {9'h058, 9'h102};
    mem[3] = {9'h05A, 9'h05A};
    for (int i = 4; i < 8; i++) mem[i] = 18'd0;
    // bits are consumed LSB first
    vecs[0] = '{8'd0, 16'h001A, 5'd5, 32'd3, 4'd0, 3, 32'h00434241, 5, 1'b0};
    vecs[1] = '{8'd0, 16'h001A, 5'd5, 32'd3, 4'd3, 3, 32'h00434241, 5, 1'b0};
    vecs[2] = '{8'd3, 16'h0005, 5'd3, 32'd3, 4'd0, 3, 32'h005A5A5A, 3, 1'b0};
    vecs[3] = '{8'd2, 16'h00FF, 5'd8, 32'd5, 4'd0, 0, 32'h00000000, 4, 1'b1};
    vecs[4] = '{8'd0, 16'h0007, 5'd4, 32'd2, 4'd1, 2, 32'h00004243, 4, 1'b0};

    nrst = 1'b0; en_state = 4'd0; root_idx = 8'd0; total_chars = 32'd0;
    char_ready = 1'b1; ack_dly = 4'd0; bits_cur = 16'd0; nbits_cur = 5'd0; clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, node_req}, 32'd0);
    chk("rst_addr", {24'd0, node_addr}, 32'd0);
    chk("rst_bitrdy", {31'd0, bit_ready}, 32'd0);
    chk("rst_cvld", {31'd0, char_valid}, 32'd0);
    chk("rst_char", {24'd0, char_out}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_fin", {28'd0, fin_state}, 32'd0);
    nrst = 1'b1;

    for (int v = 0; v < 5; v++) begin
      string nm;
      nm = $sformatf("vec%0d", v);
      load(vecs[v].root, vecs[v].bits, vecs[v].nbits, vecs[v].tot, vecs[v].dly);
      en_state = 4'd6;
      wait_fin(nm);
      chk({nm, "_n"}, {28'd0, cap_n}, vecs[v].exp_n);
      for (int c = 0; c < vecs[v].exp_n; c++)
        chk($sformatf("%s_c%0d", nm, c), {24'd0, cap[c]}, {24'd0, vecs[v].exp_c[8*c +: 8]});
      chk({nm, "_used"}, {27'd0, bit_idx}, vecs[v].exp_used);
      chk({nm, "_err"}, {31'd0, err}, {31'd0, vecs[v].exp_err});
      chk({nm, "_reqstable"}, run_bad, 32'd0);
      en_state = 4'd0;
      @(negedge clk);
      chk({nm, "_idle_fin"}, {28'd0, fin_state}, 32'd0);
      chk({nm, "_idle_err"}, {31'd0, err}, 32'd0);
    end

    // Downstream stall on the second symbol.
    load(8'd0, 16'h001A, 5'd5, 32'd3, 4'd0);
    en_state = 4'd6;
    for (int n = 0; n < 50 && !(char_valid && char_out == 8'h41); n++) @(negedge clk);
    chk("stall_first", {31'd0, char_valid}, 32'd1);
    @(negedge clk);
    char_ready = 1'b0;
    for (int n = 0; n < 50 && !char_valid; n++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_vld", k), {31'd0, char_valid}, 32'd1);
      chk($sformatf("stall%0d_char", k), {24'd0, char_out}, 32'h42);
      chk($sformatf("stall%0d_bitrdy", k), {31'd0, bit_ready}, 32'd0);
      chk($sformatf("stall%0d_req", k), {31'd0, node_req}, 32'd0);
      @(negedge clk);
    end
    char_ready = 1'b1;
    wait_fin("stall");
    chk_abc("stall");
    en_state = 4'd0;

    // Zero characters requested.
    load(8'd0, 16'h0000, 5'd0, 32'd0, 4'd0);
    en_state = 4'd6;
    @(negedge clk);
    chk("zero_fin", {28'd0, fin_state}, 32'd6);
    @(negedge clk);
    chk("zero_req", req_cnt, 32'd0);
    chk("zero_bitrdy", br_cnt, 32'd0);
    chk("zero_err", {31'd0, err}, 32'd0);
    en_state = 4'd0;

    // Abort mid-walk, then reset mid-fetch, then a clean restart.
    load(8'd0, 16'h001A, 5'd5, 32'd3, 4'd0);
    en_state = 4'd6;
    for (int n = 0; n < 50 && !bit_ready; n++) @(negedge clk);
    chk("abort_walk", {31'd0, bit_ready}, 32'd1);
    en_state = 4'd0;
    #1;
    chk("abort_bitrdy", {31'd0, bit_ready}, 32'd0);
    chk("abort_req", {31'd0, node_req}, 32'd0);
    @(negedge clk);
    chk("abort_fin", {28'd0, fin_state}, 32'd0);
    chk("abort_cvld", {31'd0, char_valid}, 32'd0);
    load(8'd0, 16'h001A, 5'd5, 32'd3, 4'd2);
    en_state = 4'd6;
    for (int n = 0; n < 50 && !node_req; n++) @(negedge clk);
    chk("rstmid_fetch", {31'd0, node_req}, 32'd1);
    nrst = 1'b0; clr = 1'b1;
    #1;
    chk("rstmid_req", {31'd0, node_req}, 32'd0);
    chk("rstmid_addr", {24'd0, node_addr}, 32'd0);
    chk("rstmid_fin", {28'd0, fin_state}, 32'd0);
    chk("rstmid_cvld", {31'd0, char_valid}, 32'd0);
    @(negedge clk);
    nrst = 1'b1; clr = 1'b0;
    wait_fin("restart");
    chk_abc("restart");
    chk("restart_used", {27'd0, bit_idx}, 32'd5);
    en_state = 4'd0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
